// File: rtl/e1_rx_framer_pkg.sv
// Shared E1 framing definitions: frame alignment word, frame geometry and
// the receive-side check positions derived from them.
package e1_rx_framer_pkg;

    localparam logic [6:0]  FAS_PATTERN   = 7'b0011011;
    localparam int unsigned FRAME_LEN     = 256;
    // TS0 bit 2 as it sits inside the checked byte {shreg[6:0], in_data}
    localparam int unsigned NFAS_BIT2_IDX = 6;

    localparam logic [8:0]  FAS_CHK_POS   = 9'd7;
    localparam logic [8:0]  NFAS_CHK_POS  = 9'(FRAME_LEN + 7);
    localparam logic [8:0]  POS_AFTER_FAS = 9'd8;

    function automatic logic fas_match(input logic [7:0] chk_byte);
        return chk_byte[6:0] == FAS_PATTERN;
    endfunction

endpackage

// File: rtl/e1_rx_framer.sv
// E1 receive framer: hunts for the FAS, confirms with NFAS bit 2 and a second
// FAS, then tags every bit with its timeslot/bit position while aligned.
module e1_rx_framer
    import e1_rx_framer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_data,
    input  logic       in_valid,
    output logic       out_data,
    output logic       out_valid,
    output logic [4:0] out_ts,
    output logic [2:0] out_bit,
    output logic       out_odd,
    output logic       out_aligned,
    output logic       out_err_fas,
    output logic       out_loss
);

    typedef enum logic [1:0] {
        SEARCH,
        CHK_NFAS,
        CHK_FAS,
        ALIGNED
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] shreg;
    logic [8:0] pos;
    logic [8:0] pos_nxt;
    logic [1:0] err_cnt;
    logic [1:0] err_cnt_nxt;
    logic       err_nxt;
    logic       loss_nxt;
    logic [7:0] chk;

    assign chk = {shreg[6:0], in_data};

    always_comb begin
        state_nxt   = state;
        pos_nxt     = pos;
        err_cnt_nxt = err_cnt;
        err_nxt     = 1'b0;
        loss_nxt    = 1'b0;
        if (in_valid) begin
            pos_nxt = pos + 9'd1;
            unique case (state)
                SEARCH: begin
                    // The position counter only runs once a candidate FAS is seen
                    pos_nxt = pos;
                    if (fas_match(chk)) begin
                        pos_nxt   = POS_AFTER_FAS;
                        state_nxt = CHK_NFAS;
                    end
                end
                CHK_NFAS: begin
                    if (pos == NFAS_CHK_POS)
                        state_nxt = chk[NFAS_BIT2_IDX] ? CHK_FAS : SEARCH;
                end
                CHK_FAS: begin
                    if (pos == FAS_CHK_POS)
                        state_nxt = fas_match(chk) ? ALIGNED : SEARCH;
                end
                ALIGNED: begin
                    if (pos == FAS_CHK_POS) begin
                        if (fas_match(chk)) begin
                            err_cnt_nxt = '0;
                        end else begin
                            err_nxt = 1'b1;
                            if (err_cnt == 2'd2) begin
                                loss_nxt    = 1'b1;
                                err_cnt_nxt = '0;
                                state_nxt   = SEARCH;
                            end else begin
                                err_cnt_nxt = err_cnt + 2'd1;
                            end
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SEARCH;
            pos     <= '0;
            shreg   <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pos     <= pos_nxt;
            err_cnt <= err_cnt_nxt;
            if (in_valid)
                shreg <= chk;
        end
    end

    // Position fields hold their last value between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= 1'b0;
            out_ts      <= '0;
            out_bit     <= '0;
            out_odd     <= 1'b0;
            out_err_fas <= 1'b0;
            out_loss    <= 1'b0;
        end else begin
            out_valid   <= in_valid && (state == ALIGNED);
            out_err_fas <= err_nxt;
            out_loss    <= loss_nxt;
            if (in_valid && (state == ALIGNED)) begin
                out_data <= in_data;
                out_ts   <= pos[7:3];
                out_bit  <= pos[2:0];
                out_odd  <= pos[8];
            end
        end
    end

    assign out_aligned = (state == ALIGNED);

endmodule
